// File: rtl/wm8731_pkg.sv
// ----------------------------------------------------------------------------
// wm8731_pkg
// Shared definitions for the WM8731 I2C control-port responder:
//   - default 7-bit device address (CSB low)
//   - register index constants of the WM8731 control map
//   - responder FSM state type
//   - reg_default(): power-on value of each implemented register
// No ports (package).
// ----------------------------------------------------------------------------
package wm8731_pkg;

   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
   localparam int         NUM_REGS         = 10;

   localparam logic [3:0] R_LINVOL  = 4'd0;
   localparam logic [3:0] R_RINVOL  = 4'd1;
   localparam logic [3:0] R_LOUTVOL = 4'd2;
   localparam logic [3:0] R_ROUTVOL = 4'd3;
   localparam logic [3:0] R_APANA   = 4'd4;
   localparam logic [3:0] R_DPATH   = 4'd5;
   localparam logic [3:0] R_PWR     = 4'd6;
   localparam logic [3:0] R_IFACE   = 4'd7;
   localparam logic [3:0] R_SRATE   = 4'd8;
   localparam logic [3:0] R_ACTIVE  = 4'd9;
   localparam logic [3:0] R_RESET   = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_ACK_A  = 3'd2,
      ST_BYTE_H = 3'd3,
      ST_ACK_H  = 3'd4,
      ST_BYTE_L = 3'd5,
      ST_ACK_L  = 3'd6,
      ST_IGNORE = 3'd7
   } state_e;

   // Power-on value of register idx; unimplemented indices read as zero.
   function automatic logic [8:0] reg_default(input logic [3:0] idx);
      logic [8:0] val;
      case (idx)
         R_LINVOL:  val = 9'h097;
         R_RINVOL:  val = 9'h097;
         R_LOUTVOL: val = 9'h079;
         R_ROUTVOL: val = 9'h079;
         R_APANA:   val = 9'h00A;
         R_DPATH:   val = 9'h008;
         R_PWR:     val = 9'h09F;
         R_IFACE:   val = 9'h00A;
         R_SRATE:   val = 9'h000;
         R_ACTIVE:  val = 9'h000;
         default:   val = 9'h000;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/wm8731_i2c_responder_if.sv
// ----------------------------------------------------------------------------
// wm8731_i2c_responder_if
// I2C bus as seen by the responder.
//   scl    : bus clock level
//   sda    : bus data level (wired-AND of all drivers)
//   sda_oe : responder pull-down request (1 = drive SDA low)
// Modports: master (bus initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface wm8731_i2c_responder_if;
   logic scl;
   logic sda;
   logic sda_oe;

   modport master (output scl, output sda, input sda_oe);
   modport slave  (input scl, input sda, output sda_oe);
endinterface

// File: rtl/wm8731_i2c_responder_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Brings SCL/SDA into the clk_i domain and detects bus events.
//   clk_i, rst_ni : sampling clock, async active-low reset
//   scl_i, sda_i  : raw asynchronous bus lines
//   scl_rise_o    : synchronized SCL rising edge (1 cycle)
//   scl_fall_o    : synchronized SCL falling edge (1 cycle)
//   start_det_o   : SDA fell while SCL high (1 cycle)
//   stop_det_o    : SDA rose while SCL high (1 cycle)
//   sda_s_o       : synchronized SDA level
// SYNC_STAGES must be at least 2.
// ----------------------------------------------------------------------------
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o,
   output logic sda_s_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_s, sda_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Shift raw lines into the chains and keep last synchronized level for edge detection.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   // Synchronizer and edge-detect registers; reset to the idle-high bus level
   // so that leaving reset never fakes an edge on a released bus.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= {SYNC_STAGES{1'b1}};
         sda_sync_q <= {SYNC_STAGES{1'b1}};
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   // START/STOP require SCL high on both samples so an SDA change racing an
   // SCL edge is never taken as a bus condition.
   always_comb begin
      scl_rise_o  = scl_s & ~scl_prev_q;
      scl_fall_o  = ~scl_s & scl_prev_q;
      start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      sda_s_o     = sda_s;
   end

endmodule

// File: rtl/wm8731_i2c_responder.sv
// ----------------------------------------------------------------------------
// wm8731_i2c_responder
// Stand-in for the WM8731 control port: acknowledges write transfers to
// DEV_ADDR, decodes {addr[6:0], data[8:0]} and commits it to a register file
// holding WM8731 power-on defaults.
//   clk_i, rst_ni : sampling clock (>= 8x SCL), async active-low reset
//   bus           : I2C lines (slave modport); bus.sda_oe pulls SDA low
//   reg_we_o      : one-cycle pulse per complete word
//   reg_addr_o    : register address of last word
//   reg_data_o    : data of last word
//   busy_o        : address-matched write in progress
//   rd_addr_i     : register file readback index
//   rd_data_o     : register file content (combinational), 0 for 10-15
// ----------------------------------------------------------------------------
module wm8731_i2c_responder
   import wm8731_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   wm8731_i2c_responder_if.slave          bus,
   output logic                           reg_we_o,
   output logic [6:0]                     reg_addr_o,
   output logic [8:0]                     reg_data_o,
   output logic                           busy_o,
   input  logic [3:0]                     rd_addr_i,
   output logic [8:0]                     rd_data_o
);

   logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .scl_i       (bus.scl),
      .sda_i       (bus.sda),
      .scl_rise_o  (scl_rise_s),
      .scl_fall_o  (scl_fall_s),
      .start_det_o (start_det_s),
      .stop_det_o  (stop_det_s),
      .sda_s_o     (sda_s)
   );

   state_e      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  hi_q, hi_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        we_q, we_d;
   logic [6:0]  addr_q, addr_d;
   logic [8:0]  data_q, data_d;
   logic [8:0]  regs_q [NUM_REGS];
   logic [8:0]  regs_d [NUM_REGS];

   logic        byte_state_s;
   logic        byte_done_s;
   logic        commit_s;
   logic [6:0]  commit_addr_s;
   logic [8:0]  commit_data_s;

   // Bits are shifted only in the three data-receiving states; a byte is
   // complete on the SCL fall that ends its 8th bit.
   always_comb begin
      byte_state_s = (state_q == ST_ADDR) || (state_q == ST_BYTE_H) || (state_q == ST_BYTE_L);
      byte_done_s  = byte_state_s && scl_fall_s && (bit_cnt_q == 4'd8);
   end

   // FSM next-state, ACK drive and commit decode.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      hi_d          = hi_q;
      sda_oe_d      = sda_oe_q;
      busy_d        = busy_q;
      we_d          = 1'b0;
      addr_d        = addr_q;
      data_d        = data_q;
      commit_s      = 1'b0;
      commit_addr_s = {hi_q[7:1]};
      commit_data_s = {hi_q[0], shift_q};

      if (start_det_s) begin
         // Repeated START restarts address reception; busy drops only if the
         // new address turns out not to match.
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else if (stop_det_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         if (byte_state_s && scl_rise_s && (bit_cnt_q < 4'd8)) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end else begin
            shift_d   = shift_q;
         end

         case (state_q)
            ST_ADDR: begin
               if (byte_done_s) begin
                  bit_cnt_d = 4'd0;
                  // Write-only device: read requests fall into IGNORE (NACK).
                  if ((shift_q[7:1] == DEV_ADDR) && (shift_q[0] == 1'b0)) begin
                     state_d  = ST_ACK_A;
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                  end else begin
                     state_d  = ST_IGNORE;
                     busy_d   = 1'b0;
                  end
               end else begin
                  state_d = ST_ADDR;
               end
            end
            ST_BYTE_H: begin
               if (byte_done_s) begin
                  bit_cnt_d = 4'd0;
                  hi_d      = shift_q;
                  state_d   = ST_ACK_H;
                  sda_oe_d  = 1'b1;
               end else begin
                  state_d = ST_BYTE_H;
               end
            end
            ST_BYTE_L: begin
               if (byte_done_s) begin
                  bit_cnt_d = 4'd0;
                  state_d   = ST_ACK_L;
                  sda_oe_d  = 1'b1;
               end else begin
                  state_d = ST_BYTE_L;
               end
            end
            ST_ACK_A: begin
               if (scl_fall_s) begin
                  state_d  = ST_BYTE_H;
                  sda_oe_d = 1'b0;
               end else begin
                  state_d = ST_ACK_A;
               end
            end
            ST_ACK_H: begin
               if (scl_fall_s) begin
                  state_d  = ST_BYTE_L;
                  sda_oe_d = 1'b0;
               end else begin
                  state_d = ST_ACK_H;
               end
            end
            ST_ACK_L: begin
               // shift_q still holds the low byte here: no shifting in ACK states.
               if (scl_fall_s) begin
                  state_d  = ST_IGNORE;
                  sda_oe_d = 1'b0;
                  we_d     = 1'b1;
                  addr_d   = hi_q[7:1];
                  data_d   = {hi_q[0], shift_q};
                  commit_s = 1'b1;
               end else begin
                  state_d = ST_ACK_L;
               end
            end
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_IGNORE: begin
               state_d  = ST_IGNORE;
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   // Register-file update: address 15 restores defaults, 0-9 write, others no-op.
   always_comb begin
      regs_d = regs_q;
      if (commit_s) begin
         if (commit_addr_s == {3'b000, R_RESET}) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               regs_d[i] = reg_default(4'(i));
            end
         end else if (commit_addr_s < 7'd10) begin
            regs_d[commit_addr_s[3:0]] = commit_data_s;
         end else begin
            regs_d = regs_q;
         end
      end else begin
         regs_d = regs_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= 8'd0;
         hi_q      <= 8'd0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 7'd0;
         data_q    <= 9'd0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= reg_default(4'(i));
         end
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         hi_q      <= hi_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Combinational readback; indices beyond the implemented map read zero.
   always_comb begin
      if (rd_addr_i < 4'd10) begin
         rd_data_o = regs_q[rd_addr_i];
      end else begin
         rd_data_o = 9'd0;
      end
   end

   assign bus.sda_oe = sda_oe_q;
   assign reg_we_o   = we_q;
   assign reg_addr_o = addr_q;
   assign reg_data_o = data_q;
   assign busy_o     = busy_q;

endmodule

// File: doc/wm8731_i2c_responder.md
Name: wm8731_i2c_responder

Overview:
- Behavioural/synthesizable model of the WM8731 control-port end of the I2C link: the responder to the team's I2C configuration initiator.
- Detects START/STOP, matches the device address, ACKs, and decodes the two-byte WM8731 word (7-bit register address + 9-bit data).
- Commits each decoded word to an internal register file with WM8731 power-on defaults.
- Used in loopback simulation and on-FPGA self-check of the config sequence, in place of the real codec.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address to acknowledge (WM8731 with CSB low).
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk_i  input  1  sampling clock; must be at least 8x the SCL rate.
- rst_ni  input  1  reset.
- scl_i  input  1  I2C clock, asynchronous to clk_i.
- sda_i  input  1  I2C data as seen on the bus, asynchronous to clk_i.
- sda_oe_o  output  1  1 = pull SDA low (open drain); 0 = release.
- reg_we_o  output  1  one-cycle pulse: a complete word was received.
- reg_addr_o  output  7  register address of the last word received.
- reg_data_o  output  9  data of the last word received.
- busy_o  output  1  high from an address-matched START until STOP.
- rd_addr_i  input  4  register file readback index.
- rd_data_o  output  9  register file content at rd_addr_i (combinational).

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - sda_oe_o=0, reg_we_o=0, reg_addr_o=0, reg_data_o=0, busy_o=0, state=IDLE.
  - Register file: R0=0x097, R1=0x097, R2=0x079, R3=0x079, R4=0x00A, R5=0x008, R6=0x09F, R7=0x00A, R8=0x000, R9=0x000.
- Input conditioning:
  - scl_i and sda_i each pass through SYNC_STAGES flip-flops, then one edge-detect register.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Data bits are sampled on the synchronized SCL rising edge, MSB first.
- States: IDLE, ADDR, ACK_A, BYTE_H, ACK_H, BYTE_L, ACK_L, IGNORE.
- Transitions:
  - START in any state -> ADDR with the bit counter cleared; this covers repeated START.
  - STOP in any state -> IDLE, sda_oe_o released, no commit.
  - ADDR, after 8 bits:
    - Address matches DEV_ADDR and R/W=0 -> ACK_A.
    - Mismatch or R/W=1 -> IGNORE. The WM8731 is write-only, so reads are not acknowledged.
  - ACK_x: sda_oe_o asserts on the SCL falling edge that ends bit 8. It releases on the next SCL falling edge, at which point the state advances: ACK_A->BYTE_H, ACK_H->BYTE_L, ACK_L->IGNORE.
  - BYTE_H: 8 bits = {addr[6:0], data[8]}. BYTE_L: 8 bits = data[7:0].
  - IGNORE: sda_oe_o stays 0 until START or STOP. Any third or later data byte is therefore NACKed.
- Commit, on the SCL falling edge that ends ACK_L:
  - reg_we_o pulses high for exactly one clk_i cycle.
  - reg_addr_o and reg_data_o update in the same cycle and hold until the next commit.
  - Register file: addresses 0-9 are written. Address 15 (reset) restores all defaults regardless of data. Addresses 10-14 and 16-127 update no register, but reg_we_o still pulses.
- Latency: sda_oe_o changes within SYNC_STAGES+2 clk_i cycles of the SCL falling edge.
- busy_o: set on entry to ACK_A; cleared on STOP, or on a START whose address then mismatches.
- rd_data_o: returns 0 for indices 10-15.
- Reset asserted mid-transfer: immediate return to the reset values. SDA is released and a partial word is discarded.
- Simultaneous START and SCL-edge detection cannot occur, because START requires SCL high and stable.

Decomposition:
- Shared package wm8731_pkg holds:
  - DEV_ADDR default.
  - Register index constants (R_LINVOL..R_ACTIVE, R_RESET=15).
  - The 10 default values.
  - The state enum typedef.
- Sub-module i2c_line_sync: synchronizers plus edge detection, outputting scl_rise, scl_fall, start_det, stop_det and sda_s.
- Register file and FSM stay in the top module.

Test Plan:
- Write to R4: START, 0x34, 0x08, 0x12, STOP.
  - Three ACK slots driven low.
  - Exactly one reg_we_o pulse with addr=4, data=0x012.
  - rd_addr_i=4 -> rd_data_o=0x012; busy_o low after STOP.
- Wrong device: START, 0x36, ...
  - sda_oe_o never asserts; no reg_we_o; busy_o stays 0; R0-R9 unchanged.
- Read request: START, 0x35 -> address slot NACKed (sda_oe_o=0) and no write.
- Aborted word: START, 0x34, 0x0C, STOP (before low byte) -> no reg_we_o and R6 remains 0x09F.
  - Then repeated START mid BYTE_L followed by a full R6=0x000 write -> commit occurs with data 0x000.
- Reset command: write R0=0x017, then R15=0x000.
  - Second commit pulses reg_we_o with addr=15.
  - R0 reads back 0x097 afterwards.
- Reset mid-ACK: assert rst_ni low while sda_oe_o=1 -> sda_oe_o=0 on the same cycle, registers at defaults.
  - A subsequent full write R2=0x07F completes normally.
